ray_aabb_result_checker: RTL

Synthesizable on-chip scoreboard that consumes the `hit_miss` stream of a Ray_AABB intersection core and classifies every result against a golden high-precision bit. It takes the golden bit at the moment its test vector is launched into the core. It then delays that bit by the core's fixed pipeline latency and compares it with the core output. Type1 errors (missed true hits) and Type2 errors (false hits) are counted in hardware, so error rates can be measured on silicon without a simulator.

---
 rtl/ray_aabb_result_checker.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ray_aabb_result_checker.sv
// Ray_AABB result checker: delays golden bits by the core latency and counts Type1/Type2 errors.
// Optional first-fail capture outputs are enabled by defining RAABB_CHK_FIRST_FAIL_EN.
module ray_aabb_result_checker #(
  parameter int LATENCY   = 39,
  parameter int NUM_TESTS = 10000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             exp_hit,
  input  logic             hit_miss,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] type1_cnt,
  output logic [CNT_W-1:0] type2_cnt,
  output logic [CNT_W-1:0] checked_cnt
`ifdef RAABB_CHK_FIRST_FAIL_EN
  ,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx
`endif
);

  localparam int TW = $clog2(NUM_TESTS + 1);
  localparam logic [TW-1:0] N_T = TW'(NUM_TESTS);
  localparam logic [CNT_W-1:0] SAT = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [CNT_W-1:0] t1_q, t1_d;
  logic [CNT_W-1:0] t2_q, t2_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [TW-1:0] launch_q, launch_d;
  logic [TW-1:0] cmp_q, cmp_d;
  logic [LATENCY-1:0] dv_q, dv_d;
  logic [LATENCY-1:0] de_q, de_d;
  logic ffv_q, ffv_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic acc;
  logic slot_exp;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    t1_d     = t1_q;
    t2_d     = t2_q;
    chk_d    = chk_q;
    launch_d = launch_q;
    cmp_d    = cmp_q;
    ffv_d    = ffv_q;
    ffi_d    = ffi_q;
    acc      = 1'b0;
    slot_exp = de_q[LATENCY-1];
    // Outside RUN the delay line drains with zeros
    dv_d     = dv_q << 1;
    de_d     = de_q << 1;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          t1_d     = '0;
          t2_d     = '0;
          chk_d    = '0;
          launch_d = '0;
          cmp_d    = '0;
          ffv_d    = 1'b0;
          ffi_d    = '0;
          dv_d     = '0;
          de_d     = '0;
        end
      end
      S_RUN: begin
        acc     = vec_valid && (launch_q < N_T);
        dv_d[0] = acc;
        de_d[0] = exp_hit;
        if (acc) begin
          launch_d = launch_q + TW'(1);
        end
        if (dv_q[LATENCY-1]) begin
          if (slot_exp && !hit_miss && t1_q != SAT) begin
            t1_d = t1_q + CNT_W'(1);
          end
          if (!slot_exp && hit_miss && t2_q != SAT) begin
            t2_d = t2_q + CNT_W'(1);
          end
          if (chk_q != SAT) begin
            chk_d = chk_q + CNT_W'(1);
          end
          if ((slot_exp ^ hit_miss) && !ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = chk_q;
          end
          cmp_d = cmp_q + TW'(1);
          if (cmp_q == N_T - TW'(1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      t1_q     <= '0;
      t2_q     <= '0;
      chk_q    <= '0;
      launch_q <= '0;
      cmp_q    <= '0;
      dv_q     <= '0;
      de_q     <= '0;
      ffv_q    <= 1'b0;
      ffi_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      chk_q    <= chk_d;
      launch_q <= launch_d;
      cmp_q    <= cmp_d;
      dv_q     <= dv_d;
      de_q     <= de_d;
      ffv_q    <= ffv_d;
      ffi_q    <= ffi_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign type1_cnt   = t1_q;
  assign type2_cnt   = t2_q;
  assign checked_cnt = chk_q;

`ifdef RAABB_CHK_FIRST_FAIL_EN
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;
`else
  logic unused_ff;
  assign unused_ff = ^{ffv_q, ffi_q};
`endif

endmodule
